// File: rtl/ps2_key_dispatcher_if.sv
// ps2_key_dispatcher_if: scan-byte input and key-event output bundle of the PS/2 key dispatcher.
interface ps2_key_dispatcher_if #(
   parameter int FIFO_DEPTH = 4
);
   logic                        rx_done_tick;
   logic [7:0]                  rx_data;
   logic                        evt_valid;
   logic                        evt_ready;
   logic [7:0]                  evt_code;
   logic                        evt_ext;
   logic                        evt_break;
   logic [$clog2(FIFO_DEPTH):0] fifo_count;
   logic                        overflow;
   logic                        ovf_clr;
   modport master (
      output rx_done_tick, rx_data, evt_ready, ovf_clr,
      input  evt_valid, evt_code, evt_ext, evt_break, fifo_count, overflow
   );
   modport slave (
      input  rx_done_tick, rx_data, evt_ready, ovf_clr,
      output evt_valid, evt_code, evt_ext, evt_break, fifo_count, overflow
   );
endinterface

// File: rtl/ps2_key_dispatcher.sv
// ps2_key_dispatcher: parses E0/F0-prefixed PS/2 scan bytes into key events and queues them in a FIFO.
module ps2_key_dispatcher #(
   parameter int FIFO_DEPTH     = 4,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input logic                 clk,
   input logic                 reset,
   ps2_key_dispatcher_if.slave bus
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int TW = $clog2(TIMEOUT_CYCLES);
   // bit0 of the state marks E0 seen, bit1 marks F0 seen
   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_EXT     = 2'd1;
   localparam logic [1:0] S_BRK     = 2'd2;
   localparam logic [1:0] S_EXT_BRK = 2'd3;

   logic [1:0]    r_state;
   logic [TW-1:0] r_tmo;
   logic [9:0]    r_mem [0:FIFO_DEPTH-1];
   logic [AW-1:0] r_rd;
   logic [AW-1:0] r_wr;
   logic [AW:0]   r_count;
   logic          r_ovf;
   logic [1:0]    w_next;
   logic          w_e0;
   logic          w_f0;
   logic          w_status;
   logic          w_push;
   logic          w_pop;
   logic          w_full;
   logic          w_accept;
   logic          w_tmo;
   logic          w_valid;
   logic [9:0]    w_head;

   assign w_e0     = bus.rx_data == 8'hE0;
   assign w_f0     = bus.rx_data == 8'hF0;
   assign w_status = bus.rx_data inside {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF};
   // status bytes are only filtered from IDLE; after a prefix they are taken as codes
   assign w_push   = bus.rx_done_tick & ~w_e0 & ~w_f0 & ~((r_state == S_IDLE) & w_status);

   always_comb begin
      w_next = S_IDLE;
      case (r_state)
         S_IDLE:  w_next = w_e0 ? S_EXT : w_f0 ? S_BRK : S_IDLE;
         S_EXT:   w_next = w_f0 ? S_EXT_BRK : w_e0 ? S_EXT : S_IDLE;
         S_BRK:   w_next = w_f0 ? S_BRK : S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   assign w_tmo = r_tmo == TW'(TIMEOUT_CYCLES - 1);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_tmo   <= '0;
      end else if (bus.rx_done_tick) begin
         r_state <= w_next;
         r_tmo   <= '0;
      end else if (r_state != S_IDLE) begin
         r_state <= w_tmo ? S_IDLE : r_state;
         r_tmo   <= w_tmo ? '0 : r_tmo + TW'(1);
      end else begin
         r_tmo   <= '0;
      end
   end

   assign w_valid  = r_count != '0;
   assign w_pop    = w_valid & bus.evt_ready;
   assign w_full   = r_count == (AW+1)'(FIFO_DEPTH);
   assign w_accept = w_push & (~w_full | w_pop);

   always_ff @(posedge clk) begin
      if (w_accept) r_mem[r_wr] <= {r_state[1], r_state[0], bus.rx_data};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rd    <= '0;
         r_wr    <= '0;
         r_count <= '0;
         r_ovf   <= 1'b0;
      end else begin
         r_rd    <= r_rd + AW'(w_pop);
         r_wr    <= r_wr + AW'(w_accept);
         r_count <= r_count + (AW+1)'(w_accept) - (AW+1)'(w_pop);
         r_ovf   <= (w_push & w_full & ~w_pop) | (r_ovf & ~bus.ovf_clr);
      end
   end

   // head fields read as zero while empty so reset and idle outputs are clean
   assign w_head         = w_valid ? r_mem[r_rd] : '0;
   assign bus.evt_valid  = w_valid;
   assign bus.evt_code   = w_head[7:0];
   assign bus.evt_ext    = w_head[8];
   assign bus.evt_break  = w_head[9];
   assign bus.fifo_count = r_count;
   assign bus.overflow   = r_ovf;
endmodule

// File: tb/tb_ps2_key_dispatcher.sv
// tb_ps2_key_dispatcher: vector table plus hand sequences for timeout and asynchronous reset.
module tb_ps2_key_dispatcher;
   localparam int T = 20;
   logic clk = 1'b0;
   logic reset = 1'b0;
   int checks = 0;
   int errors = 0;

   ps2_key_dispatcher_if #(.FIFO_DEPTH(4)) bus ();
   ps2_key_dispatcher #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(T)) dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   // expected word: {valid, code, ext, break, count, overflow}
   typedef struct {
      logic        tick;
      logic [7:0]  data;
      logic        rdy;
      logic        clr;
      logic [14:0] exp;
   } vec_t;
   vec_t tbl[$];

   function automatic logic [14:0] e(logic v, logic [7:0] c, logic x, logic b, logic [2:0] n, logic o);
      return {v, c, x, b, n, o};
   endfunction

   task automatic add(logic t, logic [7:0] d, logic r, logic c, logic [14:0] x);
      tbl.push_back('{t, d, r, c, x});
   endtask

   task automatic drive(logic t, logic [7:0] d, logic r, logic c);
      bus.rx_done_tick = t;
      bus.rx_data      = d;
      bus.evt_ready    = r;
      bus.ovf_clr      = c;
   endtask

   task automatic step(logic t, logic [7:0] d, logic r, logic c);
      drive(t, d, r, c);
      @(posedge clk);
      #1;
      drive(1'b0, 8'h00, 1'b0, 1'b0);
   endtask

   task automatic check(string name, int idx, logic [14:0] exp);
      logic [14:0] got;
      got = {bus.evt_valid, bus.evt_code, bus.evt_ext, bus.evt_break, bus.fifo_count, bus.overflow};
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s[%0d] got v=%b code=%h ext=%b brk=%b cnt=%0d ovf=%b expected v=%b code=%h ext=%b brk=%b cnt=%0d ovf=%b",
                  name, idx, got[14], got[13:6], got[5], got[4], got[3:1], got[0],
                  exp[14], exp[13:6], exp[5], exp[4], exp[3:1], exp[0]);
      end
   endtask

   initial begin
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      // single make, prefixes, discards, protocol errors
      add(0, 8'h00, 0, 0, 0);
      add(1, 8'h1C, 0, 0, 0);
      add(0, 8'h00, 0, 0, e(1, 8'h1C, 0, 0, 1, 0));
      add(0, 8'h00, 1, 0, e(1, 8'h1C, 0, 0, 1, 0));
      add(0, 8'h00, 0, 0, 0);
      add(1, 8'hE0, 0, 0, 0);
      add(1, 8'hF0, 0, 0, 0);
      add(1, 8'h75, 0, 0, 0);
      add(0, 8'h00, 0, 0, e(1, 8'h75, 1, 1, 1, 0));
      add(1, 8'hF0, 1, 0, e(1, 8'h75, 1, 1, 1, 0));
      add(1, 8'h1C, 0, 0, 0);
      add(0, 8'h00, 0, 0, e(1, 8'h1C, 0, 1, 1, 0));
      add(1, 8'hAA, 1, 0, e(1, 8'h1C, 0, 1, 1, 0));
      add(1, 8'hFA, 0, 0, 0);
      add(1, 8'hEE, 0, 0, 0);
      add(1, 8'hE0, 0, 0, 0);
      add(1, 8'hE0, 0, 0, 0);
      add(1, 8'h74, 0, 0, 0);
      add(0, 8'h00, 0, 0, e(1, 8'h74, 1, 0, 1, 0));
      add(0, 8'h00, 1, 0, e(1, 8'h74, 1, 0, 1, 0));
      add(1, 8'h00, 0, 0, 0);
      add(1, 8'hFF, 0, 0, 0);
      add(1, 8'hFE, 0, 0, 0);
      add(1, 8'hF0, 0, 0, 0);
      add(1, 8'hE0, 0, 0, 0);
      add(1, 8'h12, 0, 0, 0);
      add(0, 8'h00, 1, 0, e(1, 8'h12, 0, 0, 1, 0));
      add(1, 8'hE0, 0, 0, 0);
      add(1, 8'hF0, 0, 0, 0);
      add(1, 8'hF0, 0, 0, 0);
      add(1, 8'h5A, 0, 0, 0);
      add(0, 8'h00, 1, 0, e(1, 8'h5A, 0, 0, 1, 0));
      add(0, 8'h00, 0, 0, 0);
      // overflow with five makes, ordered drain, sticky clear
      add(1, 8'h15, 0, 0, 0);
      add(1, 8'h1D, 0, 0, e(1, 8'h15, 0, 0, 1, 0));
      add(1, 8'h24, 0, 0, e(1, 8'h15, 0, 0, 2, 0));
      add(1, 8'h2D, 0, 0, e(1, 8'h15, 0, 0, 3, 0));
      add(1, 8'h2C, 0, 0, e(1, 8'h15, 0, 0, 4, 0));
      add(0, 8'h00, 0, 0, e(1, 8'h15, 0, 0, 4, 1));
      add(0, 8'h00, 1, 0, e(1, 8'h15, 0, 0, 4, 1));
      add(0, 8'h00, 1, 0, e(1, 8'h1D, 0, 0, 3, 1));
      add(0, 8'h00, 1, 0, e(1, 8'h24, 0, 0, 2, 1));
      add(0, 8'h00, 1, 0, e(1, 8'h2D, 0, 0, 1, 1));
      add(0, 8'h00, 0, 1, e(0, 8'h00, 0, 0, 0, 1));
      add(0, 8'h00, 0, 0, 0);
      // full with simultaneous push/pop, then set-over-clear priority
      add(1, 8'h15, 0, 0, 0);
      add(1, 8'h1D, 0, 0, e(1, 8'h15, 0, 0, 1, 0));
      add(1, 8'h24, 0, 0, e(1, 8'h15, 0, 0, 2, 0));
      add(1, 8'h2D, 0, 0, e(1, 8'h15, 0, 0, 3, 0));
      add(0, 8'h00, 0, 0, e(1, 8'h15, 0, 0, 4, 0));
      add(1, 8'h2C, 1, 0, e(1, 8'h15, 0, 0, 4, 0));
      add(1, 8'h33, 0, 1, e(1, 8'h1D, 0, 0, 4, 0));
      add(0, 8'h00, 0, 0, e(1, 8'h1D, 0, 0, 4, 1));
      add(0, 8'h00, 1, 0, e(1, 8'h1D, 0, 0, 4, 1));
      add(0, 8'h00, 1, 0, e(1, 8'h24, 0, 0, 3, 1));
      add(0, 8'h00, 1, 0, e(1, 8'h2D, 0, 0, 2, 1));
      add(0, 8'h00, 1, 0, e(1, 8'h2C, 0, 0, 1, 1));
      add(0, 8'h00, 0, 1, e(0, 8'h00, 0, 0, 0, 1));
      add(0, 8'h00, 1, 0, 0);
      add(0, 8'h00, 0, 0, 0);

      repeat (2) @(posedge clk);
      #1;
      check("reset", 0, 0);
      reset = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].tick, tbl[i].data, tbl[i].rdy, tbl[i].clr);
         @(negedge clk);
         check("vec", i, tbl[i].exp);
         @(posedge clk);
         #1;
      end
      drive(1'b0, 8'h00, 1'b0, 1'b0);

      // code arriving one cycle before the timeout still completes the prefix
      step(1, 8'hE0, 0, 0);
      repeat (T - 2) step(0, 8'h00, 0, 0);
      step(1, 8'h74, 0, 0);
      check("tmo_edge", 0, e(1, 8'h74, 1, 0, 1, 0));
      step(0, 8'h00, 1, 0);
      check("tmo_edge_pop", 0, 0);
      step(1, 8'hE0, 0, 0);
      repeat (T) step(0, 8'h00, 0, 0);
      check("tmo_idle", 0, 0);
      step(1, 8'h29, 0, 0);
      check("tmo_resync", 0, e(1, 8'h29, 0, 0, 1, 0));
      step(0, 8'h00, 1, 0);
      check("tmo_pop", 0, 0);

      // asynchronous reset in the middle of E0 F0 with a full, overflowed FIFO
      foreach (tbl[i]) if (i < 5) step(1, 8'h15 + 8'(i), 0, 0);
      step(1, 8'hE0, 0, 0);
      step(1, 8'hF0, 0, 0);
      check("pre_rst", 0, e(1, 8'h15, 0, 0, 4, 1));
      reset = 1'b0;
      #2;
      check("rst_async", 0, 0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      step(1, 8'hF0, 0, 0);
      step(1, 8'h12, 0, 0);
      check("post_rst", 0, e(1, 8'h12, 0, 1, 1, 0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
